// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ core and its memory responder.
// READ_LATENCY is the number of clock edges from address presentation to
// valid read data; the core derives its wait-state count from it.
package subleq_pkg;

    typedef logic [31:0] word_t;

    localparam int    DEFAULT_ADDR_W    = 10;
    localparam word_t DEFAULT_MMIO_ADDR = 32'h0000_03FF;
    localparam int    READ_LATENCY      = 2;

endpackage

// File: rtl/subleq_ram_2p.sv
// Raw DEPTH x DATA_W storage with two synchronous read ports and a
// prioritised write (the "hi" write overrides the "lo" write on an address
// clash). Reads are read-first: a write on the same edge as a read is not
// seen by that read.
// Ports:
//   clock, rst            clock; async active-high reset (read data regs only)
//   rd_en_x, rd_zero_x    load read register this edge; force it to zero
//   rd_addr_x, rd_data_x  read address; registered read data
//   wr_hi_*, wr_lo_*      write enable / address / data, hi has priority
module subleq_ram_2p
    import subleq_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              rd_en_a,
    input  logic              rd_zero_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_en_b,
    input  logic              rd_zero_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_hi_en,
    input  logic [ADDR_W-1:0] wr_hi_addr,
    input  logic [DATA_W-1:0] wr_hi_data,
    input  logic              wr_lo_en,
    input  logic [ADDR_W-1:0] wr_lo_addr,
    input  logic [DATA_W-1:0] wr_lo_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

    // Contents are never reset. The hi write is issued last so it wins a clash.
    always_ff @(posedge clock) begin
        if (wr_lo_en) mem[wr_lo_addr] <= wr_lo_data;
        if (wr_hi_en) mem[wr_hi_addr] <= wr_hi_data;
    end

    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_en_a) rd_data_a_d = rd_zero_a ? '0 : mem[rd_addr_a];
        if (rd_en_b) rd_data_b_d = rd_zero_b ? '0 : mem[rd_addr_b];
    end

    // ---- read data stage ----
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: rtl/subleq_mem_responder.sv
// Memory-side responder for the SUBLEQ core. Serves two read/write ports
// with a fixed two-edge read latency, merges writes from port 1, the
// program-load port and port 2 (in that priority), decodes one MMIO output
// register and keeps a sticky out-of-range flag.
// Ports:
//   clock, rst                      clock; async active-high reset
//   en_1/we_1/addr_1/din_1/dout_1   port 1 (operand B, write-back)
//   en_2/we_2/addr_2/din_2/dout_2   port 2 (PC, operand A)
//   ld_valid/ld_ready/ld_addr/ld_data  program-load handshake
//   mmio_out, mmio_strobe           MMIO register and one-cycle write pulse
//   addr_err                        sticky out-of-range access flag
module subleq_mem_responder
    import subleq_pkg::*;
#(
    parameter int    ADDR_W    = DEFAULT_ADDR_W,
    parameter int    DATA_W    = 32,
    parameter word_t MMIO_ADDR = DEFAULT_MMIO_ADDR
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              en_1,
    input  logic              we_1,
    input  logic [31:0]       addr_1,
    input  logic [DATA_W-1:0] din_1,
    output logic [DATA_W-1:0] dout_1,
    input  logic              en_2,
    input  logic              we_2,
    input  logic [31:0]       addr_2,
    input  logic [DATA_W-1:0] din_2,
    output logic [DATA_W-1:0] dout_2,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] mmio_out,
    output logic              mmio_strobe,
    output logic              addr_err
);

    function automatic logic in_range(input word_t a);
        return (a >> ADDR_W) == '0;
    endfunction

    logic              wr_1, ld_xfer, wr_2;
    logic              pri_req, pri_ok, sec_ok, pri_mmio, sec_mmio;
    word_t             pri_addr;
    logic [DATA_W-1:0] pri_data;
    logic              acc_err;

    logic              rd1_vld_q, rd1_vld_d, rd1_oor_q, rd1_oor_d;
    logic              rd2_vld_q, rd2_vld_d, rd2_oor_q, rd2_oor_d;
    logic [ADDR_W-1:0] rd1_addr_q, rd1_addr_d, rd2_addr_q, rd2_addr_d;
    logic [DATA_W-1:0] mmio_out_q, mmio_out_d;
    logic              mmio_strobe_q, mmio_strobe_d;
    logic              addr_err_q, addr_err_d;

    // Port 1 writes and load transfers are mutually exclusive through
    // ld_ready, so they share the high-priority write path.
    assign wr_1     = en_1 & we_1;
    assign ld_ready = ~wr_1;
    assign ld_xfer  = ld_valid & ld_ready;
    assign wr_2     = en_2 & we_2;

    always_comb begin
        pri_req  = wr_1 | ld_xfer;
        pri_addr = wr_1 ? addr_1 : ld_addr;
        pri_data = wr_1 ? din_1 : ld_data;
        pri_ok   = pri_req & in_range(pri_addr);
        sec_ok   = wr_2 & in_range(addr_2);
        pri_mmio = pri_ok & (pri_addr == MMIO_ADDR);
        sec_mmio = sec_ok & (addr_2 == MMIO_ADDR);
        acc_err  = (en_1 & ~in_range(addr_1))
                 | (en_2 & ~in_range(addr_2))
                 | (ld_xfer & ~in_range(ld_addr));

        mmio_out_d    = mmio_out_q;
        if (sec_mmio) mmio_out_d = din_2;
        if (pri_mmio) mmio_out_d = pri_data;
        mmio_strobe_d = pri_mmio | sec_mmio;
        addr_err_d    = addr_err_q | acc_err;

        // A write access is not also a read, so it leaves dout untouched.
        rd1_vld_d  = en_1 & ~we_1;
        rd1_oor_d  = ~in_range(addr_1);
        rd1_addr_d = addr_1[ADDR_W-1:0];
        rd2_vld_d  = en_2 & ~we_2;
        rd2_oor_d  = ~in_range(addr_2);
        rd2_addr_d = addr_2[ADDR_W-1:0];
    end

    // ---- address stage (E0) and control registers ----
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd1_vld_q     <= 1'b0;
            rd1_oor_q     <= 1'b0;
            rd1_addr_q    <= '0;
            rd2_vld_q     <= 1'b0;
            rd2_oor_q     <= 1'b0;
            rd2_addr_q    <= '0;
            mmio_out_q    <= '0;
            mmio_strobe_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            rd1_vld_q     <= rd1_vld_d;
            rd1_oor_q     <= rd1_oor_d;
            rd1_addr_q    <= rd1_addr_d;
            rd2_vld_q     <= rd2_vld_d;
            rd2_oor_q     <= rd2_oor_d;
            rd2_addr_q    <= rd2_addr_d;
            mmio_out_q    <= mmio_out_d;
            mmio_strobe_q <= mmio_strobe_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // ---- array access and read data stage (E1) ----
    subleq_ram_2p #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock      (clock),
        .rst        (rst),
        .rd_en_a    (rd1_vld_q),
        .rd_zero_a  (rd1_oor_q),
        .rd_addr_a  (rd1_addr_q),
        .rd_data_a  (dout_1),
        .rd_en_b    (rd2_vld_q),
        .rd_zero_b  (rd2_oor_q),
        .rd_addr_b  (rd2_addr_q),
        .rd_data_b  (dout_2),
        .wr_hi_en   (pri_ok),
        .wr_hi_addr (pri_addr[ADDR_W-1:0]),
        .wr_hi_data (pri_data),
        .wr_lo_en   (sec_ok),
        .wr_lo_addr (addr_2[ADDR_W-1:0]),
        .wr_lo_data (din_2)
    );

    assign mmio_out    = mmio_out_q;
    assign mmio_strobe = mmio_strobe_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_subleq_mem_responder.sv
// Scoreboard bench for subleq_mem_responder: a reference memory model
// predicts each read result and MMIO/error state; a monitor compares on the
// falling edge.
module tb_subleq_mem_responder;
    import subleq_pkg::*;

    localparam int    DEPTH = 1024;
    localparam word_t MMIO  = 32'h0000_03FF;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        en_1 = 0, we_1 = 0, en_2 = 0, we_2 = 0, ld_valid = 0;
    logic [31:0] addr_1 = 0, din_1 = 0, addr_2 = 0, din_2 = 0, ld_addr = 0, ld_data = 0;
    logic [31:0] dout_1, dout_2, mmio_out;
    logic        ld_ready, mmio_strobe, addr_err;

    subleq_mem_responder dut (
        .clock(clock), .rst(rst),
        .en_1(en_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1), .dout_1(dout_1),
        .en_2(en_2), .we_2(we_2), .addr_2(addr_2), .din_2(din_2), .dout_2(dout_2),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .mmio_out(mmio_out), .mmio_strobe(mmio_strobe), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [31:0] val;
    } rd_t;

    rd_t         q1[$];
    rd_t         q2[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_mmio = 0, exp_d1 = 0, exp_d2 = 0;
    logic        exp_strobe = 0, exp_err = 0;
    int          cyc = 0;
    int          total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < DEPTH) return mem_m[a[9:0]];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (a < DEPTH) begin
            mem_m[a[9:0]] = d;
            if (a == MMIO) begin
                exp_mmio   = d;
                exp_strobe = 1'b1;
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Reference model: applies each edge's writes lowest priority first, then
    // predicts the reads sampled on the same edge (they see those writes).
    initial forever begin
        @(posedge clock or posedge rst);
        if (rst) begin
            q1.delete();
            q2.delete();
            exp_mmio   = 0;
            exp_strobe = 0;
            exp_err    = 0;
        end else begin
            logic w1, lx, w2;
            cyc++;
            w1 = en_1 && we_1;
            lx = ld_valid && !w1;
            w2 = en_2 && we_2;
            exp_strobe = 0;
            if (w2) model_write(addr_2, din_2);
            if (lx) model_write(ld_addr, ld_data);
            if (w1) model_write(addr_1, din_1);
            if (en_1 && addr_1 >= DEPTH) exp_err = 1'b1;
            if (en_2 && addr_2 >= DEPTH) exp_err = 1'b1;
            if (en_1 && !we_1) q1.push_back('{cyc + 1, model_read(addr_1)});
            if (en_2 && !we_2) q2.push_back('{cyc + 1, model_read(addr_2)});
        end
    end

    // Monitor: retire due reads, then compare every observable output.
    initial forever begin
        @(negedge clock);
        if (rst) begin
            exp_d1 = 0;
            exp_d2 = 0;
        end else begin
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                exp_d1 = q1[0].val;
                void'(q1.pop_front());
            end
            while (q2.size() > 0 && q2[0].due <= cyc) begin
                exp_d2 = q2[0].val;
                void'(q2.pop_front());
            end
        end
        chk("dout_1", dout_1, exp_d1);
        chk("dout_2", dout_2, exp_d2);
        chk("mmio_out", mmio_out, exp_mmio);
        chk("mmio_strobe", {31'b0, mmio_strobe}, {31'b0, exp_strobe});
        chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, !(en_1 && we_1)});
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        en_1 = 0; we_1 = 0; en_2 = 0; we_2 = 0; ld_valid = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r < 12) return 32'($urandom_range(0, 15));
        if (r < 14) return MMIO;
        if (r == 14) return 32'h400 + 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    initial begin
        repeat (3) tick();
        rst = 0;
        tick();

        // Preload the whole array through the load port.
        for (int a = 0; a < DEPTH; a++) begin
            ld_valid = 1; ld_addr = a; ld_data = $urandom;
            tick();
        end
        idle(); tick();

        // Load 0x11 at 5, then a single port 2 read and a quiet hold period.
        ld_valid = 1; ld_addr = 5; ld_data = 32'h11; tick();
        idle(); tick();
        en_2 = 1; addr_2 = 5; tick();
        idle(); repeat (4) tick();

        // Read-first collision at address 7.
        ld_valid = 1; ld_addr = 7; ld_data = 3; tick();
        idle(); en_2 = 1; addr_2 = 7; tick();
        en_2 = 0; en_1 = 1; we_1 = 1; addr_1 = 7; din_1 = 9; tick();
        idle(); en_2 = 1; addr_2 = 7; tick();
        idle(); repeat (3) tick();

        // Same-cycle writes to address 4 from both ports.
        en_1 = 1; we_1 = 1; addr_1 = 4; din_1 = 32'hA;
        en_2 = 1; we_2 = 1; addr_2 = 4; din_2 = 32'hB; tick();
        idle(); en_1 = 1; addr_1 = 4; tick();
        idle(); repeat (3) tick();

        // MMIO write, readback, then back-to-back MMIO writes from port 2.
        en_1 = 1; we_1 = 1; addr_1 = MMIO; din_1 = 32'h2A; tick();
        idle(); repeat (2) tick();
        en_2 = 1; addr_2 = MMIO; tick();
        idle(); repeat (2) tick();
        en_2 = 1; we_2 = 1; addr_2 = MMIO; din_2 = 32'h77; tick();
        din_2 = 32'h78; tick();
        idle(); repeat (3) tick();

        // Load backpressured by port 1 writes, then released.
        ld_valid = 1; ld_addr = 20; ld_data = 32'h55;
        en_1 = 1; we_1 = 1; addr_1 = 21; din_1 = 32'h66; repeat (2) tick();
        en_1 = 0; we_1 = 0; tick();
        idle(); en_1 = 1; addr_1 = 20; en_2 = 1; addr_2 = 21; tick();
        idle(); repeat (3) tick();

        // Out-of-range write must not alias onto address 0; read returns 0.
        en_1 = 1; we_1 = 1; addr_1 = 32'h400; din_1 = 32'hDEAD; tick();
        idle(); en_1 = 1; addr_1 = 32'h400; tick();
        en_1 = 1; addr_1 = 0; tick();
        idle(); repeat (4) tick();

        // Reset between the address and data edges of a read.
        en_1 = 1; addr_1 = 5; tick();
        idle(); rst = 1; repeat (2) tick();
        rst = 0; tick();
        en_1 = 1; addr_1 = 5; en_2 = 1; addr_2 = 7; tick();
        idle(); repeat (3) tick();

        // Random traffic; a stalled load keeps its address and data.
        for (int i = 0; i < 3000; i++) begin
            if (!(ld_valid && en_1 && we_1)) begin
                ld_valid = ($urandom_range(0, 3) == 0);
                ld_addr  = rand_addr();
                ld_data  = $urandom;
            end
            en_1 = $urandom_range(0, 1); we_1 = $urandom_range(0, 1);
            addr_1 = rand_addr(); din_1 = $urandom;
            en_2 = $urandom_range(0, 1); we_2 = ($urandom_range(0, 7) == 0);
            addr_2 = rand_addr(); din_2 = $urandom;
            tick();
        end
        idle(); repeat (4) tick();

        chk("rd1_queue_drained", q1.size(), 0);
        chk("rd2_queue_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/subleq_mem_responder.md
Name: subleq_mem_responder

Overview:
Memory-side responder for the SUBLEQ core's two memory ports. Port 1 is read/write (operand B, write-back); port 2 is read/write-capable but driven read-only by the core (PC, operand A). It serves reads with a fixed 2-cycle latency, which matches the core's address / wait / latch sequencing. It also decodes one MMIO output register and provides a valid/ready program-load port used while the core is held in reset.

Parameters:
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words
DATA_W, 32, word width
MMIO_ADDR, 32'h0000_03FF, word address whose writes update mmio_out

Ports:
clock  input  1  system clock
rst  input  1  asynchronous, active-high reset
en_1  input  1  port 1 access enable
we_1  input  1  port 1 write enable (qualified by en_1)
addr_1  input  32  port 1 word address
din_1  input  DATA_W  port 1 write data
dout_1  output  DATA_W  port 1 read data, 2 cycles after address
en_2  input  1  port 2 access enable
we_2  input  1  port 2 write enable (qualified by en_2)
addr_2  input  32  port 2 word address
din_2  input  DATA_W  port 2 write data
dout_2  output  DATA_W  port 2 read data, 2 cycles after address
ld_valid  input  1  program-load word valid
ld_ready  output  1  load port can accept
ld_addr  input  32  load word address
ld_data  input  DATA_W  load word
mmio_out  output  DATA_W  last value written to MMIO_ADDR
mmio_strobe  output  1  1-cycle pulse on each MMIO write
addr_err  output  1  sticky out-of-range access flag

Behaviour:
- Reset (async, rst=1):
  - dout_1, dout_2, mmio_out and addr_err go to 0; mmio_strobe goes to 0.
  - Read pipeline registers are cleared.
  - Array contents are retained, not reset.
  - A reset mid-read discards that read: dout stays 0 until a new read completes.
- Address decode:
  - An address is in range iff addr[31:ADDR_W]==0.
  - Out-of-range write: dropped, sets addr_err.
  - Out-of-range read: returns 0, sets addr_err.
  - addr_err stays set until rst.
- Read timing, per port, fully pipelined (one new address per cycle):
  - Edge E0: en and addr sampled into stage 1.
  - Edge E1: array read into the dout register.
  - dout is valid after E1 and holds until the next completed read.
  - If en=0 at E0, that slot does not update dout.
- Write:
  - The array is written at the edge where en&we=1, using addr and din of that cycle.
  - An access with en&we=1 is not also a read: dout holds.
- Read/write ordering: read-first at E1.
  - A write committed at or before E0 is visible to the read.
  - A write committed on E1 itself, to the same address, is not visible; the read returns the old word.
- Same-address simultaneous writes on ports 1 and 2: port 1 wins.
- MMIO:
  - Any in-range write to MMIO_ADDR (port 1, port 2 or load) also updates mmio_out at that edge.
  - mmio_strobe is high for exactly the following cycle.
  - The word is also stored in the array; reads return it.
  - Back-to-back MMIO writes give a strobe each cycle.
  - On simultaneous MMIO writes, the same priority applies as for the array write.
- Load port:
  - ld_ready = !(en_1 & we_1), so port 1 writes have priority.
  - A transfer occurs at an edge where ld_valid & ld_ready are both 1.
  - A transfer writes ld_data to ld_addr and obeys the same range and MMIO rules.
  - Load versus port 2 write to the same address: the load wins.
  - ld_addr and ld_data must be held while ld_valid=1 and ld_ready=0.
- Write priority overall (same address): port 1 > load > port 2.

Decomposition:
- Package subleq_pkg holds:
  - word_t (logic [31:0])
  - DEFAULT_ADDR_W and DEFAULT_MMIO_ADDR
  - READ_LATENCY=2, shared with the core FSM so wait-state counts derive from one constant
- Sub-module subleq_ram_2p:
  - Raw DEPTH x DATA_W array, read-first.
  - Two synchronous read ports plus a single prioritised write.
  - Priority merge and MMIO decode stay in the top level.

Test Plan:
- Load then read:
  - Load 0x11 at addr 5 via ld handshake.
  - Drive addr_2=5, en_2=1 for 1 cycle.
  - dout_2 = 0x11 exactly 2 edges later and holds while en_2=0.
- Read-first collision:
  - Array[7]=3. Port 1 writes 9 to addr 7 on E1 of a port 2 read of addr 7.
  - dout_2 = 3; the next read returns 9.
- Dual write conflict:
  - Port 1 writes 0xA and port 2 writes 0xB to addr 4 in the same cycle.
  - A later read returns 0xA.
- MMIO:
  - Port 1 writes 0x2A to MMIO_ADDR.
  - mmio_out = 0x2A the next cycle, mmio_strobe high for exactly 1 cycle.
  - A read of MMIO_ADDR returns 0x2A.
- Out of range:
  - Port 1 writes to addr 0x400 (ADDR_W=10) → addr_err=1, array unchanged.
  - A read of 0x400 → dout_1=0.
  - addr_err stays 1 until rst.
- Backpressure and reset:
  - Hold ld_valid with en_1=we_1=1 → ld_ready=0, no load write.
  - Drop we_1 → transfer occurs.
  - Assert rst mid-read → dout_1=0, mmio_out=0, and previously loaded words remain readable afterwards.
